// File: rtl/mpsram_wr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mpsram_wr_sched_if
// Purpose  : Requester handshake and SRAM write-port bundle for mpsram_wr_sched.
// Revision : 1.0  initial release
// ============================================================================
interface mpsram_wr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 2,
    parameter int W       = 32,
    parameter int AW      = 3
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*W-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  init;
    logic                  mem_busy_w;
    logic [NUM_W-1:0]      wen;
    logic [NUM_W*AW-1:0]   waddr;
    logic [NUM_W*W-1:0]    wdata;
    logic                  busy;

    modport master (
        output req_valid, req_addr, req_data, init, mem_busy_w,
        input  req_ready, wen, waddr, wdata, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, init, mem_busy_w,
        output req_ready, wen, waddr, wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mpsram_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mpsram_wr_sched
// Purpose  : Round-robin scheduler of write requesters onto NUM_W SRAM write
//            ports, with address-conflict skipping and a zero-fill INIT mode.
// Revision : 1.0  initial release
// ============================================================================
module mpsram_wr_sched #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 2,
    parameter int W       = 32,
    parameter int N       = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mpsram_wr_sched_if.slave bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_W-1:0]    wen_q, wen_d;
    logic [NUM_W*AW-1:0] waddr_q, waddr_d;
    logic [NUM_W*W-1:0]  wdata_q, wdata_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  grant;
    logic [AW-1:0]       gaddr [NUM_W];
    logic                dup;
    int                  n_gnt;
    int                  last;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        wen_d    = '0;
        waddr_d  = '0;
        wdata_d  = '0;
        grant    = '0;
        dup      = 1'b0;
        n_gnt    = 0;
        last     = 0;
        for (int k = 0; k < NUM_W; k++) gaddr[k] = '0;

        case (state_q)
            ST_RUN: begin
                if (!bus.mem_busy_w) begin
                    // Visit requesters in rotated order starting at rr_ptr.
                    for (int j = 0; j < NUM_REQ; j++) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (i == (int'(rr_ptr_q) + j) % NUM_REQ) begin
                                dup = 1'b0;
                                for (int k = 0; k < NUM_W; k++) begin
                                    if (k < n_gnt && gaddr[k] == bus.req_addr[i*AW +: AW]) dup = 1'b1;
                                end
                                if (bus.req_valid[i] && n_gnt < NUM_W && !dup) begin
                                    grant[i] = 1'b1;
                                    for (int k = 0; k < NUM_W; k++) begin
                                        if (k == n_gnt) begin
                                            wen_d[k]             = 1'b1;
                                            waddr_d[k*AW +: AW]  = bus.req_addr[i*AW +: AW];
                                            wdata_d[k*W +: W]    = bus.req_data[i*W +: W];
                                            gaddr[k]             = bus.req_addr[i*AW +: AW];
                                        end
                                    end
                                    n_gnt = n_gnt + 1;
                                    last  = i;
                                end
                            end
                        end
                    end
                    if (n_gnt > 0) rr_ptr_d = RW'((last + 1) % NUM_REQ);
                end
                if (bus.init) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                if (!bus.mem_busy_w) begin
                    for (int k = 0; k < NUM_W; k++) begin
                        if (int'(cnt_q) + k < N) begin
                            wen_d[k]            = 1'b1;
                            waddr_d[k*AW +: AW] = AW'(int'(cnt_q) + k);
                        end
                    end
                    cnt_d = cnt_q + CW'(NUM_W);
                    if (int'(cnt_q) + NUM_W >= N) state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        busy_d = (state_d == ST_INIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wen_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    // Grants are only computed in RUN without stall; reset masks them directly.
    assign bus.req_ready = rst ? grant : '0;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mpsram_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpsram_wr_sched
// Purpose  : Directed and randomized checking of mpsram_wr_sched against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpsram_wr_sched;
    localparam int NUM_REQ = 4;
    localparam int NUM_W   = 2;
    localparam int W       = 32;
    localparam int N       = 8;
    localparam int AW      = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpsram_wr_sched_if #(.NUM_REQ(NUM_REQ), .NUM_W(NUM_W), .W(W), .AW(AW)) bus ();

    mpsram_wr_sched #(.NUM_REQ(NUM_REQ), .NUM_W(NUM_W), .W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int busy_seen;

    bit                  m_init, n_init;
    int                  m_cnt, n_cnt, m_rr, n_rr;
    logic [NUM_W-1:0]    m_wen, n_wen;
    logic [NUM_W*AW-1:0] m_waddr, n_waddr;
    logic [NUM_W*W-1:0]  m_wdata, n_wdata;
    logic [NUM_REQ-1:0]  e_ready, obs_ready;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init = 0; m_cnt = 0; m_rr = 0;
        m_wen = '0; m_waddr = '0; m_wdata = '0;
    endtask

    // Decide this cycle's grants / fill writes from the current inputs.
    task automatic model_eval();
        int q[$];
        int n, last, i, a;
        bit dup;
        e_ready = '0; n_wen = '0; n_waddr = '0; n_wdata = '0;
        n_init = m_init; n_cnt = m_cnt; n_rr = m_rr;
        if (!m_init) begin
            if (!bus.mem_busy_w) begin
                n = 0; last = -1;
                for (int j = 0; j < NUM_REQ; j++) begin
                    i = (m_rr + j) % NUM_REQ;
                    a = int'(bus.req_addr[i*AW +: AW]);
                    dup = 0;
                    foreach (q[g]) if (q[g] == a) dup = 1;
                    if (bus.req_valid[i] && n < NUM_W && !dup) begin
                        e_ready[i] = 1'b1;
                        q.push_back(a);
                        n_wen[n] = 1'b1;
                        n_waddr[n*AW +: AW] = AW'(a);
                        n_wdata[n*W +: W] = bus.req_data[i*W +: W];
                        n++;
                        last = i;
                    end
                end
                if (last >= 0) n_rr = (last + 1) % NUM_REQ;
            end
            if (bus.init) begin
                n_init = 1; n_cnt = 0;
            end
        end else if (!bus.mem_busy_w) begin
            for (int k = 0; k < NUM_W; k++) begin
                if (m_cnt + k < N) begin
                    n_wen[k] = 1'b1;
                    n_waddr[k*AW +: AW] = AW'(m_cnt + k);
                end
            end
            n_cnt = m_cnt + NUM_W;
            if (n_cnt >= N) n_init = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        obs_ready = bus.req_ready;
        if (bus.busy) busy_seen++;
        check_eq("req_ready", bus.req_ready, e_ready);
        check_eq("wen", bus.wen, m_wen);
        check_eq("busy", bus.busy, m_init);
        for (int k = 0; k < NUM_W; k++) begin
            if (m_wen[k]) begin
                check_eq("waddr", bus.waddr[k*AW +: AW], m_waddr[k*AW +: AW]);
                check_eq("wdata", bus.wdata[k*W +: W], m_wdata[k*W +: W]);
            end
        end
        @(posedge clk);
        #1;
        m_init = n_init; m_cnt = n_cnt; m_rr = n_rr;
        m_wen = n_wen; m_waddr = n_waddr; m_wdata = n_wdata;
    endtask

    task automatic set_req(input int i, input bit v, input int addr);
        bus.req_valid[i] = v;
        bus.req_addr[i*AW +: AW] = AW'(addr);
        bus.req_data[i*W +: W] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = '1; bus.req_addr = '0; bus.req_data = '0;
        bus.init = 1'b0; bus.mem_busy_w = 1'b0;
        #2 rst = 1'b0;
        #10;
        check_eq("rst_ready", bus.req_ready, '0);
        check_eq("rst_wen", bus.wen, '0);
        check_eq("rst_waddr", bus.waddr, '0);
        check_eq("rst_wdata", bus.wdata, '0);
        check_eq("rst_busy", bus.busy, 1'b0);
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();

        // Four distinct addresses: two per cycle in requester order.
        for (int i = 0; i < 4; i++) set_req(i, 1, i + 1);
        step(); check_eq("rr_c0_ready", obs_ready, 4'b0011);
        bus.req_valid &= ~e_ready;
        step(); check_eq("rr_c1_ready", obs_ready, 4'b1100);
        bus.req_valid &= ~e_ready;
        step(); step();

        // Same-address conflict: req1 is skipped in favour of req2.
        set_req(0, 1, 5); set_req(1, 1, 5); set_req(2, 1, 3);
        step(); check_eq("conf_c0_ready", obs_ready, 4'b0101);
        bus.req_valid &= ~e_ready;
        step(); check_eq("conf_c1_ready", obs_ready, 4'b0010);
        bus.req_valid &= ~e_ready;
        step();

        // Lone requester 3 wins every cycle.
        for (int a = 0; a < 3; a++) begin
            set_req(3, 1, a);
            step(); check_eq("req3_ready", obs_ready, 4'b1000);
        end
        bus.req_valid = '0;
        step(); step();

        // Write-side stall holds everything.
        set_req(0, 1, 6); set_req(1, 1, 7);
        bus.mem_busy_w = 1'b1;
        repeat (3) begin
            step(); check_eq("stall_ready", obs_ready, 4'b0000);
        end
        bus.mem_busy_w = 1'b0;
        step(); check_eq("unstall_ready", obs_ready, 4'b0011);
        bus.req_valid &= ~e_ready;
        step();

        // Zero fill from idle; a second init pulse mid-fill is ignored.
        busy_seen = 0;
        bus.init = 1'b1; step(); bus.init = 1'b0;
        set_req(2, 1, 4);
        step();
        bus.init = 1'b1; step(); bus.init = 1'b0;
        repeat (3) step();
        check_eq("init_busy_cycles", busy_seen, 4);
        bus.req_valid &= ~e_ready;
        step();

        // Reset during the second fill cycle aborts the fill.
        bus.init = 1'b1; step(); bus.init = 1'b0;
        set_req(1, 1, 2);
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", bus.req_ready, '0);
        check_eq("abort_wen", bus.wen, '0);
        check_eq("abort_waddr", bus.waddr, '0);
        check_eq("abort_wdata", bus.wdata, '0);
        check_eq("abort_busy", bus.busy, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        step(); check_eq("post_rst_ready", obs_ready, 4'b0010);
        bus.req_valid &= ~e_ready;
        step();

        // Randomized traffic with held-until-accepted requests.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || e_ready[i])
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1));
            end
            bus.mem_busy_w = ($urandom_range(0, 5) == 0);
            bus.init       = ($urandom_range(0, 40) == 0);
            step();
        end
        bus.req_valid = '0; bus.init = 1'b0; bus.mem_busy_w = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
